// File: rtl/segre_dmem_miss_unit_pkg.sv
// Shared types and sizes for the D-cache miss unit.
// Line/index geometry, store sizes, FSM states, LRU age type.
package segre_dmem_miss_unit_pkg;

  localparam int ADDR_SIZE         = 32;
  localparam int WORD_SIZE         = 32;
  localparam int DCACHE_LANE_SIZE  = 128;
  localparam int DCACHE_INDEX_SIZE = 2;
  localparam int DCACHE_NLINES     = 2 ** DCACHE_INDEX_SIZE;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP,
    DRAIN
  } dmem_miss_state_e;

  typedef logic [DCACHE_INDEX_SIZE-1:0] dcache_lru_age_t;

endpackage

// File: rtl/segre_dmem_miss_unit_if.sv
// MEM-pipe request/response bundle plus main-memory port.
// master: pipeline + memory side; slave: miss unit.
interface segre_dmem_miss_unit_if;
  import segre_dmem_miss_unit_pkg::*;

  logic                         dc_miss_i;
  logic [ADDR_SIZE-1:0]         dc_addr_i;
  logic                         dc_access_i;
  logic [DCACHE_INDEX_SIZE-1:0] dc_access_index_i;
  logic [WORD_SIZE-1:0]         dc_data_i;
  memop_data_type_e             dc_store_data_type_i;
  logic                         dc_store_i;
  logic                         dc_data_rdy_o;
  logic [DCACHE_LANE_SIZE-1:0]  dc_data_o;
  logic [DCACHE_INDEX_SIZE-1:0] dc_lru_index_o;
  logic                         mm_rd_o;
  logic                         mm_wr_o;
  logic [ADDR_SIZE-1:0]         mm_addr_o;
  logic [WORD_SIZE-1:0]         mm_wr_data_o;
  logic [WORD_SIZE/8-1:0]       mm_wr_be_o;
  logic                         mm_rdy_i;
  logic [DCACHE_LANE_SIZE-1:0]  mm_rd_data_i;

  modport master (
    output dc_miss_i, dc_addr_i, dc_access_i,
    output dc_access_index_i, dc_data_i,
    output dc_store_data_type_i, dc_store_i,
    input  dc_data_rdy_o, dc_data_o, dc_lru_index_o,
    input  mm_rd_o, mm_wr_o, mm_addr_o,
    input  mm_wr_data_o, mm_wr_be_o,
    output mm_rdy_i, mm_rd_data_i
  );

  modport slave (
    input  dc_miss_i, dc_addr_i, dc_access_i,
    input  dc_access_index_i, dc_data_i,
    input  dc_store_data_type_i, dc_store_i,
    output dc_data_rdy_o, dc_data_o, dc_lru_index_o,
    output mm_rd_o, mm_wr_o, mm_addr_o,
    output mm_wr_data_o, mm_wr_be_o,
    input  mm_rdy_i, mm_rd_data_i
  );

endinterface

// File: rtl/segre_dmem_miss_unit_lru_age.sv
// True-LRU age counters for the D-cache lines.
// Ports: clk_i, rsn_i, touch_i/touch_index_i in, victim_o out.
module segre_lru_age
  import segre_dmem_miss_unit_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         touch_i,
  input  logic [DCACHE_INDEX_SIZE-1:0] touch_index_i,
  output logic [DCACHE_INDEX_SIZE-1:0] victim_o
);

  dcache_lru_age_t age_q [DCACHE_NLINES];
  dcache_lru_age_t age_d [DCACHE_NLINES];
  logic [DCACHE_NLINES-1:0] seen;

  always_comb begin
    for (int k = 0; k < DCACHE_NLINES; k++) begin
      age_d[k] = age_q[k];
    end
    if (touch_i) begin
      for (int k = 0; k < DCACHE_NLINES; k++) begin
        if (age_q[k] < age_q[touch_index_i]) begin
          age_d[k] = age_q[k] + dcache_lru_age_t'(1);
        end
      end
      age_d[touch_index_i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int k = 0; k < DCACHE_NLINES; k++) begin
        age_q[k] <= dcache_lru_age_t'(k);
      end
    end else begin
      for (int k = 0; k < DCACHE_NLINES; k++) begin
        age_q[k] <= age_d[k];
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int k = 0; k < DCACHE_NLINES; k++) begin
      if (age_q[k] == '1) begin
        victim_o = DCACHE_INDEX_SIZE'(k);
      end
    end
  end

  always_comb begin
    seen = '0;
    for (int k = 0; k < DCACHE_NLINES; k++) begin
      seen[age_q[k]] = 1'b1;
    end
  end

  a_age_perm: assert property (
    @(posedge clk_i) disable iff (!rsn_i) &seen
  );

endmodule

// File: rtl/segre_dmem_miss_unit.sv
// D-cache miss unit: line fills, write-through stores, LRU.
// Ports: clk_i, rsn_i, bus (slave: MEM-pipe + memory side).
module segre_dmem_miss_unit
  import segre_dmem_miss_unit_pkg::*;
(
  input logic                  clk_i,
  input logic                  rsn_i,
  segre_dmem_miss_unit_if.slave bus
);

  localparam int BE_W     = WORD_SIZE / 8;
  localparam int WORD_OFF = $clog2(BE_W);
  localparam int LINE_OFF = $clog2(DCACHE_LANE_SIZE / 8);

  dmem_miss_state_e state_q;

  logic                         rdy_q;
  logic                         rd_q;
  logic                         wr_q;
  logic                         fill_q;
  logic [DCACHE_LANE_SIZE-1:0]  data_q;
  logic [DCACHE_INDEX_SIZE-1:0] victim_q;
  logic [ADDR_SIZE-1:0]         addr_q;
  logic [WORD_SIZE-1:0]         wdata_q;
  logic [BE_W-1:0]              be_q;

  logic [DCACHE_INDEX_SIZE-1:0] lru_victim;
  logic                         fill_touch;
  logic                         touch_v;
  logic [DCACHE_INDEX_SIZE-1:0] touch_idx;

  logic [WORD_SIZE-1:0] st_data;
  logic [BE_W-1:0]      st_be;
  logic                 st_aligned;
  logic [ADDR_SIZE-1:0] line_addr;
  logic [ADDR_SIZE-1:0] word_addr;

  assign line_addr = {bus.dc_addr_i[ADDR_SIZE-1:LINE_OFF],
                      {LINE_OFF{1'b0}}};
  assign word_addr = {bus.dc_addr_i[ADDR_SIZE-1:WORD_OFF],
                      {WORD_OFF{1'b0}}};

  always_comb begin
    st_data    = bus.dc_data_i;
    st_be      = '1;
    st_aligned = 1'b1;
    unique case (bus.dc_store_data_type_i)
      BYTE: begin
        st_data = {BE_W{bus.dc_data_i[7:0]}};
        st_be   = BE_W'(1) << bus.dc_addr_i[WORD_OFF-1:0];
      end
      HALF: begin
        st_data    = {(BE_W/2){bus.dc_data_i[15:0]}};
        st_be      = BE_W'(3) <<
                     {bus.dc_addr_i[WORD_OFF-1:1], 1'b0};
        st_aligned = !bus.dc_addr_i[0];
      end
      default: begin
        st_aligned = bus.dc_addr_i[WORD_OFF-1:0] == '0;
      end
    endcase
  end

  // The fill installs at the victim; a same-cycle hit is dropped.
  assign fill_touch = (state_q == RESP) && fill_q;
  assign touch_v    = fill_touch ||
                      (bus.dc_access_i && !bus.dc_miss_i);
  assign touch_idx  = fill_touch ? victim_q
                                 : bus.dc_access_index_i;

  segre_lru_age u_lru (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .touch_i      (touch_v),
    .touch_index_i(touch_idx),
    .victim_o     (lru_victim)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      fill_q   <= 1'b0;
      data_q   <= '0;
      victim_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.dc_store_i) begin
            state_q <= WR_WAIT;
            wr_q    <= 1'b1;
            fill_q  <= 1'b0;
            addr_q  <= word_addr;
            wdata_q <= st_data;
            be_q    <= st_be;
          end else if (bus.dc_miss_i) begin
            state_q  <= RD_WAIT;
            rd_q     <= 1'b1;
            fill_q   <= 1'b1;
            addr_q   <= line_addr;
            victim_q <= lru_victim;
          end
        end
        RD_WAIT: begin
          if (bus.mm_rdy_i) begin
            state_q <= RESP;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= bus.mm_rd_data_i;
            rdy_q   <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (bus.mm_rdy_i) begin
            state_q <= RESP;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdy_q   <= 1'b1;
          end
        end
        RESP:    state_q <= DRAIN;
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dc_data_rdy_o  = rdy_q;
  assign bus.dc_data_o      = data_q;
  assign bus.dc_lru_index_o = fill_touch ? victim_q : lru_victim;
  assign bus.mm_rd_o        = rd_q;
  assign bus.mm_wr_o        = wr_q;
  assign bus.mm_addr_o      = addr_q;
  assign bus.mm_wr_data_o   = wdata_q;
  assign bus.mm_wr_be_o     = be_q;

  a_store_align: assert property (
    @(posedge clk_i) disable iff (!rsn_i)
    (state_q == IDLE && bus.dc_store_i) |-> st_aligned
  ) else $fatal(1, "misaligned store");

  a_rd_wr_excl: assert property (
    @(posedge clk_i) disable iff (!rsn_i)
    !(bus.mm_rd_o && bus.mm_wr_o)
  );

  a_req_stable: assert property (
    @(posedge clk_i) disable iff (!rsn_i)
    (state_q == RD_WAIT || state_q == WR_WAIT) |->
      ($stable(bus.dc_miss_i) && $stable(bus.dc_store_i) &&
       $stable(bus.dc_addr_i) && $stable(bus.dc_data_i) &&
       $stable(bus.dc_store_data_type_i))
  );

endmodule

// File: tb/tb_segre_dmem_miss_unit.sv
// Scoreboard bench for segre_dmem_miss_unit.
// Stimulus pushes expectations; memory and response monitors check.
module tb_segre_dmem_miss_unit;
  import segre_dmem_miss_unit_pkg::*;

  logic clk = 1'b0;
  logic rsn;
  always #5 clk = ~clk;

  segre_dmem_miss_unit_if bus();

  segre_dmem_miss_unit dut (
    .clk_i(clk),
    .rsn_i(rsn),
    .bus  (bus)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          dly;
  } mm_exp_t;

  typedef struct {
    bit           fill;
    logic [127:0] line;
    logic [1:0]   victim;
  } rsp_exp_t;

  mm_exp_t      mm_q[$];
  rsp_exp_t     rsp_q[$];
  logic [127:0] line_q[$];
  int           lru_list[$];
  logic [127:0] last_line;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_cyc = 0;
  bit mem_en = 1'b1;
  bit force_rdy = 1'b0;

  initial forever @(posedge clk) cyc++;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Recency list, most recent first; the victim is the tail.
  function automatic void model_reset();
    lru_list.delete();
    for (int k = 0; k < 4; k++) lru_list.push_back(k);
    last_line = '0;
  endfunction

  function automatic int model_victim();
    return lru_list[lru_list.size()-1];
  endfunction

  function automatic void model_touch(int i);
    int pos = 0;
    for (int k = 0; k < lru_list.size(); k++)
      if (lru_list[k] == i) pos = k;
    lru_list.delete(pos);
    lru_list.push_front(i);
  endfunction

  task automatic drive_idle();
    bus.dc_miss_i            = 1'b0;
    bus.dc_store_i           = 1'b0;
    bus.dc_access_i          = 1'b0;
    bus.dc_access_index_i    = '0;
    bus.dc_addr_i            = '0;
    bus.dc_data_i            = '0;
    bus.dc_store_data_type_i = WORD;
  endtask

  task automatic wait_rdy(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dc_data_rdy_o && n < 60);
    if (!bus.dc_data_rdy_o) begin
      total++;
      bad++;
      $display("FAIL %s: no dc_data_rdy_o within 60 cycles",
               name);
    end
  endtask

  task automatic do_hit(int i);
    bus.dc_access_i       = 1'b1;
    bus.dc_access_index_i = i[1:0];
    @(negedge clk);
    bus.dc_access_i = 1'b0;
    model_touch(i);
    chk("lru_hit", bus.dc_lru_index_o, model_victim());
  endtask

  task automatic issue_miss(logic [31:0] a, logic [127:0] line,
                            int dly, bit rhit, int hidx,
                            bit chk_first);
    int v = model_victim();
    mm_q.push_back('{1'b1, a & ~32'hF, 32'h0, 4'h0, dly});
    line_q.push_back(line);
    rsp_q.push_back('{1'b1, line, v[1:0]});
    last_line = line;
    bus.dc_miss_i = 1'b1;
    bus.dc_addr_i = a;
    if (chk_first) begin
      @(negedge clk);
      chk("rd_next_cycle", bus.mm_rd_o, 1'b1);
      chk("rd_addr_first", bus.mm_addr_o, a & ~32'hF);
    end
    wait_rdy("fill");
    bus.dc_miss_i = 1'b0;
    model_touch(v);
    if (rhit) begin
      bus.dc_access_i       = 1'b1;
      bus.dc_access_index_i = hidx[1:0];
    end
    @(negedge clk);
    bus.dc_access_i = 1'b0;
    chk("lru_after_fill", bus.dc_lru_index_o, model_victim());
  endtask

  task automatic issue_store(logic [31:0] a, logic [31:0] d,
                             memop_data_type_e t, int dly,
                             bit also_miss, bit rhit, int hidx);
    logic [31:0] wd;
    logic [3:0]  be;
    case (t)
      BYTE: begin
        wd = d[7:0] * 32'h0101_0101;
        be = 4'b0001 << a[1:0];
      end
      HALF: begin
        wd = d[15:0] * 32'h0001_0001;
        be = 4'b0011 << (a[1:0] & 2'b10);
      end
      default: begin
        wd = d;
        be = 4'b1111;
      end
    endcase
    mm_q.push_back('{1'b0, a & ~32'h3, wd, be, dly});
    rsp_q.push_back('{1'b0, last_line, 2'b00});
    bus.dc_store_i           = 1'b1;
    bus.dc_miss_i            = also_miss;
    bus.dc_addr_i            = a;
    bus.dc_data_i            = d;
    bus.dc_store_data_type_i = t;
    wait_rdy("store");
    bus.dc_store_i = 1'b0;
    if (also_miss) begin
      chk("resp_no_rd", bus.mm_rd_o, 1'b0);
      @(negedge clk);
      chk("drain_no_rd", bus.mm_rd_o, 1'b0);
      issue_miss(a, {$urandom, $urandom, $urandom, $urandom},
                 dly, 1'b0, 0, 1'b0);
    end else begin
      if (rhit) begin
        bus.dc_access_i       = 1'b1;
        bus.dc_access_index_i = hidx[1:0];
        model_touch(hidx);
      end
      @(negedge clk);
      bus.dc_access_i = 1'b0;
      chk("lru_after_store", bus.dc_lru_index_o,
          model_victim());
    end
  endtask

  // Memory: checks each request, answers after a delay.
  initial begin
    mm_exp_t e;
    int d;
    bus.mm_rdy_i     = 1'b0;
    bus.mm_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (force_rdy) begin
        force_rdy    = 1'b0;
        bus.mm_rdy_i = 1'b1;
        @(negedge clk);
        bus.mm_rdy_i = 1'b0;
      end else if (mem_en && rsn &&
                   (bus.mm_rd_o || bus.mm_wr_o)) begin
        if (mm_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mm_req: rd=%0b wr=%0b none expected",
                   bus.mm_rd_o, bus.mm_wr_o);
        end else begin
          e = mm_q.pop_front();
          chk("mm_rd", bus.mm_rd_o, e.is_rd);
          chk("mm_wr", bus.mm_wr_o, !e.is_rd);
          chk("mm_addr", bus.mm_addr_o, e.addr);
          if (!e.is_rd) begin
            chk("mm_wdata", bus.mm_wr_data_o, e.data);
            chk("mm_be", bus.mm_wr_be_o, e.be);
          end
          d = (e.dly < 0) ? $urandom_range(0, 4) : e.dly;
          repeat (d) @(negedge clk);
          if (e.is_rd) bus.mm_rd_data_i = line_q.pop_front();
          bus.mm_rdy_i = 1'b1;
          rdy_cyc      = cyc;
          @(negedge clk);
          bus.mm_rdy_i     = 1'b0;
          bus.mm_rd_data_i = {$urandom, $urandom,
                              $urandom, $urandom};
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_exp_t r;
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rsn) begin
        prev = 1'b0;
      end else begin
        if (prev)
          chk("rdy_one_cycle", bus.dc_data_rdy_o, 1'b0);
        if (bus.dc_data_rdy_o) begin
          if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp: dc_data_rdy_o=1 want 0");
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_data", bus.dc_data_o, r.line);
            if (r.fill)
              chk("rsp_victim", bus.dc_lru_index_o, r.victim);
            chk("rsp_latency", cyc, rdy_cyc + 1);
          end
        end
        prev = bus.dc_data_rdy_o;
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_rdy"}, bus.dc_data_rdy_o, 1'b0);
    chk({tag, "_data"}, bus.dc_data_o, '0);
    chk({tag, "_rd"}, bus.mm_rd_o, 1'b0);
    chk({tag, "_wr"}, bus.mm_wr_o, 1'b0);
    chk({tag, "_addr"}, bus.mm_addr_o, '0);
    chk({tag, "_wdata"}, bus.mm_wr_data_o, '0);
    chk({tag, "_be"}, bus.mm_wr_be_o, '0);
    chk({tag, "_lru"}, bus.dc_lru_index_o, 2'd3);
  endtask

  initial begin
    int op;
    int t;
    logic [31:0] a;
    drive_idle();
    model_reset();
    rsn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rsn = 1'b1;
    @(negedge clk);

    issue_miss(32'h0000_1234, {4{32'hA5A5_A5A5}}, 4,
               1'b0, 0, 1'b1);

    do_hit(3);
    do_hit(0);
    do_hit(1);
    chk("lru_hits_310", bus.dc_lru_index_o, 2'd2);
    issue_miss(32'h0000_4450, {$urandom, $urandom,
               $urandom, $urandom}, 1, 1'b0, 0, 1'b0);
    chk("lru_fill_3", bus.dc_lru_index_o, 2'd3);

    issue_store(32'h0000_0102, 32'h1234_56EF, BYTE, 2,
                1'b0, 1'b0, 0);
    issue_store(32'h0000_3004, 32'hCAFE_F00D, WORD, 1,
                1'b1, 1'b0, 0);

    issue_miss(32'h0000_8888, {$urandom, $urandom,
               $urandom, $urandom}, 2, 1'b1,
               model_victim(), 1'b0);

    mem_en = 1'b0;
    bus.dc_miss_i = 1'b1;
    bus.dc_addr_i = 32'h0000_2468;
    repeat (2) @(negedge clk);
    chk("rst_pre_rd", bus.mm_rd_o, 1'b1);
    #2 rsn = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    bus.dc_miss_i = 1'b0;
    @(negedge clk);
    rsn       = 1'b1;
    force_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("late_rdy_ignored", bus.dc_data_rdy_o, 1'b0);
    end
    mem_en = 1'b1;

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_hit($urandom_range(0, 3));
        1: issue_miss($urandom, {$urandom, $urandom,
                      $urandom, $urandom}, -1,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'b0);
        default: begin
          t = $urandom_range(0, 2);
          a = $urandom;
          if (t == 1) a[0] = 1'b0;
          if (t == 2) a[1:0] = 2'b00;
          issue_store(a, $urandom, memop_data_type_e'(t), -1,
                      op == 3, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3));
        end
      endcase
      drive_idle();
    end

    repeat (8) @(negedge clk);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("mm_q_empty", mm_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
